// File: rtl/i2cmb_cmd_pkg.sv
// Shared types for the I2CMB Wishbone command engine: register map, command
// and status codes, CMDR layout and the FSM state encoding.
package i2cmb_cmd_pkg;

   localparam logic [1:0] ADDR_CSR  = 2'd0;
   localparam logic [1:0] ADDR_DPR  = 2'd1;
   localparam logic [1:0] ADDR_CMDR = 2'd2;
   localparam logic [1:0] ADDR_FSMR = 2'd3;

   typedef enum logic [2:0] {
      CMD_WAIT     = 3'd0,
      CMD_WRITE    = 3'd1,
      CMD_READ_ACK = 3'd2,
      CMD_READ_NAK = 3'd3,
      CMD_START    = 3'd4,
      CMD_STOP     = 3'd5,
      CMD_SET_BUS  = 3'd6
   } cmd_e;

   typedef enum logic [2:0] {
      STS_OK        = 3'd0,
      STS_NAK       = 3'd1,
      STS_ARB_LOST  = 3'd2,
      STS_ERR       = 3'd3,
      STS_TIMEOUT   = 3'd4,
      STS_RSVD_VIOL = 3'd5
   } status_e;

   typedef struct packed {
      logic       don;
      logic       nak;
      logic       al;
      logic       err;
      logic       r;
      logic [2:0] cmd;
   } cmdr_fields_t;

   typedef union packed {
      logic [7:0]   raw;
      cmdr_fields_t f;
   } cmdr_u;

   // INIT_CSR must stay at 0 so the exposed state resets to zero.
   typedef enum logic [3:0] {
      S_INIT_CSR = 4'd0,
      S_IDLE     = 4'd1,
      S_WR_DPR   = 4'd2,
      S_WR_CMDR  = 4'd3,
      S_WAIT_IRQ = 4'd4,
      S_RD_CMDR  = 4'd5,
      S_RD_DPR   = 4'd6,
      S_RESP     = 4'd7
   } state_e;

   function automatic logic op_defined(logic [2:0] op);
      return op != 3'd7;
   endfunction

   function automatic logic op_uses_dpr(logic [2:0] op);
      return (op == CMD_WRITE) || (op == CMD_SET_BUS) || (op == CMD_WAIT);
   endfunction

   function automatic logic op_is_read(logic [2:0] op);
      return (op == CMD_READ_ACK) || (op == CMD_READ_NAK);
   endfunction

   // Reserved-bit violation outranks every other flag; no flag at all is an error.
   function automatic status_e cmdr_status(cmdr_u c);
      if (c.f.r)        return STS_RSVD_VIOL;
      else if (c.f.err) return STS_ERR;
      else if (c.f.al)  return STS_ARB_LOST;
      else if (c.f.nak) return STS_NAK;
      else if (c.f.don) return STS_OK;
      else              return STS_ERR;
   endfunction

endpackage

// File: rtl/i2cmb_wb_xfer.sv
// Single Wishbone transfer sequencer: a start pulse launches one registered
// cycle that is held until ack_i, then dropped on the following edge.
module i2cmb_wb_xfer #(
   parameter int AW = 2,
   parameter int DW = 8
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          start_i,
   input  logic          we_i,
   input  logic [AW-1:0] adr_i,
   input  logic [DW-1:0] wdat_i,
   output logic          done_o,
   output logic [DW-1:0] rdata_o,
   output logic          cyc_o,
   output logic          stb_o,
   output logic          we_o,
   output logic [AW-1:0] adr_o,
   output logic [DW-1:0] dat_o,
   input  logic [DW-1:0] dat_i,
   input  logic          ack_i
);

   logic          cyc_q, cyc_d;
   logic          we_q, we_d;
   logic [AW-1:0] adr_q, adr_d;
   logic [DW-1:0] dat_q, dat_d;

   // start_i is ignored while a cycle is open, so a requester may hold it.
   always_comb begin
      cyc_d = cyc_q;
      we_d  = we_q;
      adr_d = adr_q;
      dat_d = dat_q;
      if (cyc_q) begin
         if (ack_i) cyc_d = 1'b0;
      end else if (start_i) begin
         cyc_d = 1'b1;
         we_d  = we_i;
         adr_d = adr_i;
         dat_d = wdat_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cyc_q <= 1'b0;
         we_q  <= 1'b0;
         adr_q <= '0;
         dat_q <= '0;
      end else begin
         cyc_q <= cyc_d;
         we_q  <= we_d;
         adr_q <= adr_d;
         dat_q <= dat_d;
      end
   end

   assign cyc_o   = cyc_q;
   assign stb_o   = cyc_q;
   assign we_o    = we_q;
   assign adr_o   = adr_q;
   assign dat_o   = dat_q;
   assign done_o  = cyc_q & ack_i;
   assign rdata_o = dat_i;

endmodule

// File: rtl/i2cmb_wb_cmd_engine.sv
// Wishbone master front-end for I2CMB: turns byte-level I2C requests into
// CSR/DPR/CMDR transfers, waits for irq_i, and returns a status/data response.
module i2cmb_wb_cmd_engine
   import i2cmb_cmd_pkg::*;
#(
   parameter int         WB_ADDR_WIDTH  = 2,
   parameter int         WB_DATA_WIDTH  = 8,
   parameter int         TIMEOUT_CYCLES = 65535,
   parameter logic [7:0] CSR_INIT       = 8'hC0
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     req_valid_i,
   output logic                     req_ready_o,
   input  logic [2:0]               req_op_i,
   input  logic [7:0]               req_data_i,
   output logic                     rsp_valid_o,
   input  logic                     rsp_ready_i,
   output logic [2:0]               rsp_status_o,
   output logic [7:0]               rsp_data_o,
   output logic                     cyc_o,
   output logic                     stb_o,
   output logic                     we_o,
   output logic [WB_ADDR_WIDTH-1:0] adr_o,
   output logic [WB_DATA_WIDTH-1:0] dat_o,
   input  logic [WB_DATA_WIDTH-1:0] dat_i,
   input  logic                     ack_i,
   input  logic                     irq_i,
   output logic [3:0]               dbg_state_o
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   // Request and response ports are valid/ready: a beat transfers on a clock
   // edge where both are high; valid holds its payload until that edge.
   state_e                   state_q, state_d;
   logic [2:0]               op_q, op_d;
   logic [7:0]               data_q, data_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic                     rsp_valid_q, rsp_valid_d;
   logic [2:0]               rsp_status_q, rsp_status_d;
   logic [7:0]               rsp_data_q, rsp_data_d;
   logic                     req_ready_q, req_ready_d;

   logic                     xfer_start, xfer_we, xfer_done;
   logic [WB_ADDR_WIDTH-1:0] xfer_adr;
   logic [WB_DATA_WIDTH-1:0] xfer_wdat, xfer_rdata;
   cmdr_u                    rd_cmdr;
   logic                     timeout;

   assign rd_cmdr = cmdr_u'(xfer_rdata[7:0]);
   assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= S_INIT_CSR;
         op_q         <= '0;
         data_q       <= '0;
         cnt_q        <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_status_q <= '0;
         rsp_data_q   <= '0;
         req_ready_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         data_q       <= data_d;
         cnt_q        <= cnt_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_status_q <= rsp_status_d;
         rsp_data_q   <= rsp_data_d;
         req_ready_q  <= req_ready_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_INIT_CSR: if (xfer_done) state_d = S_IDLE;
         S_IDLE: begin
            if (req_valid_i) begin
               if (!op_defined(req_op_i))     state_d = S_RESP;
               else if (op_uses_dpr(req_op_i)) state_d = S_WR_DPR;
               else                            state_d = S_WR_CMDR;
            end
         end
         S_WR_DPR:   if (xfer_done) state_d = S_WR_CMDR;
         S_WR_CMDR:  if (xfer_done) state_d = S_WAIT_IRQ;
         // irq_i is checked first so it wins over a same-cycle timeout.
         S_WAIT_IRQ: begin
            if (irq_i)        state_d = S_RD_CMDR;
            else if (timeout) state_d = S_RESP;
         end
         S_RD_CMDR: begin
            if (xfer_done) begin
               if (rd_cmdr.f.don && op_is_read(op_q)) state_d = S_RD_DPR;
               else                                  state_d = S_RESP;
            end
         end
         S_RD_DPR:   if (xfer_done) state_d = S_RESP;
         S_RESP:     if (rsp_valid_q && rsp_ready_i) state_d = S_IDLE;
         default:    state_d = S_INIT_CSR;
      endcase
   end

   always_comb begin
      xfer_start   = 1'b0;
      xfer_we      = 1'b0;
      xfer_adr     = WB_ADDR_WIDTH'(ADDR_CSR);
      xfer_wdat    = '0;
      op_d         = op_q;
      data_d       = data_q;
      cnt_d        = cnt_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_status_d = rsp_status_q;
      rsp_data_d   = rsp_data_q;
      req_ready_d  = (state_d == S_IDLE);
      case (state_q)
         S_INIT_CSR: begin
            xfer_start = 1'b1;
            xfer_we    = 1'b1;
            xfer_wdat  = WB_DATA_WIDTH'(CSR_INIT);
         end
         S_IDLE: begin
            if (req_valid_i) begin
               op_d         = req_op_i;
               data_d       = req_data_i;
               rsp_data_d   = 8'h00;
               rsp_status_d = STS_OK;
               if (!op_defined(req_op_i)) begin
                  rsp_status_d = STS_ERR;
                  rsp_valid_d  = 1'b1;
               end
            end
         end
         S_WR_DPR: begin
            xfer_start = 1'b1;
            xfer_we    = 1'b1;
            xfer_adr   = WB_ADDR_WIDTH'(ADDR_DPR);
            xfer_wdat  = WB_DATA_WIDTH'(data_q);
         end
         S_WR_CMDR: begin
            xfer_start = 1'b1;
            xfer_we    = 1'b1;
            xfer_adr   = WB_ADDR_WIDTH'(ADDR_CMDR);
            xfer_wdat  = WB_DATA_WIDTH'(op_q);
            cnt_d      = '0;
         end
         S_WAIT_IRQ: begin
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            if (!irq_i && timeout) begin
               rsp_status_d = STS_TIMEOUT;
               rsp_valid_d  = 1'b1;
            end
         end
         S_RD_CMDR: begin
            xfer_start = 1'b1;
            xfer_adr   = WB_ADDR_WIDTH'(ADDR_CMDR);
            if (xfer_done) begin
               rsp_status_d = cmdr_status(rd_cmdr);
               if (!(rd_cmdr.f.don && op_is_read(op_q))) rsp_valid_d = 1'b1;
            end
         end
         S_RD_DPR: begin
            xfer_start = 1'b1;
            xfer_adr   = WB_ADDR_WIDTH'(ADDR_DPR);
            if (xfer_done) begin
               rsp_data_d  = xfer_rdata[7:0];
               rsp_valid_d = 1'b1;
            end
         end
         S_RESP: if (rsp_ready_i) rsp_valid_d = 1'b0;
         default: ;
      endcase
   end

   i2cmb_wb_xfer #(
      .AW(WB_ADDR_WIDTH),
      .DW(WB_DATA_WIDTH)
   ) u_xfer (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .start_i(xfer_start),
      .we_i   (xfer_we),
      .adr_i  (xfer_adr),
      .wdat_i (xfer_wdat),
      .done_o (xfer_done),
      .rdata_o(xfer_rdata),
      .cyc_o  (cyc_o),
      .stb_o  (stb_o),
      .we_o   (we_o),
      .adr_o  (adr_o),
      .dat_o  (dat_o),
      .dat_i  (dat_i),
      .ack_i  (ack_i)
   );

   assign req_ready_o  = req_ready_q;
   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_status_o = rsp_status_q;
   assign rsp_data_o   = rsp_data_q;
   assign dbg_state_o  = state_q;

endmodule
